// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice datapath.
//
// Contents:
//   alu_op_e         - 3-bit opcode encoding used on the S input.
//   alu_is_arith()   - true for opcodes that route through the add/sub path
//                      (the only ones whose carry-out reaches CO).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS_B = 3'b000,
        OP_RSVD1  = 3'b001,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110,
        OP_RSVD7  = 3'b111
    } alu_op_e;

    function automatic logic alu_is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_add_sub.sv
// Combinational add/subtract core of the ALU slice.
//
// Ports:
//   a    [WIDTH-1:0] in   operand A
//   b    [WIDTH-1:0] in   operand B
//   ci               in   carry-in to the LSB
//   sub              in   1 = invert B before adding (A + ~B + ci)
//   sum  [WIDTH-1:0] out  low WIDTH bits of the sum
//   co               out  carry out of the MSB
//
// Subtraction does not force the carry-in: a true two's-complement A-B
// needs ci=1 from the caller, which keeps chained slices uniform.
module alu_add_sub #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   total;

    assign b_eff = b ^ {WIDTH{sub}};

    // One extra bit of headroom so the MSB carry lands in total[WIDTH].
    assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ci};

    assign sum = total[WIDTH-1:0];
    assign co  = total[WIDTH];

endmodule

// File: rtl/bit_alu_slice.sv
// Registered ALU slice: pass-B, add, subtract, AND, OR, XOR.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset (clears out and CO)
//   A    [WIDTH-1:0] in   operand A
//   B    [WIDTH-1:0] in   operand B
//   CI               in   carry-in (used only by add/subtract)
//   S    [2:0]       in   opcode, see alu_pkg::alu_op_e
//   out  [WIDTH-1:0] out  registered result
//   CO               out  registered carry-out (0 for non-arithmetic ops)
//
// Timing: there is no valid/ready handshake. Every rising edge with
// reset=0 captures the result of the inputs present before that edge, and
// it is visible on out/CO until the following edge. Reset wins over any
// operation presented in the same cycle.
module bit_alu_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] out,
    output logic             CO
);

    alu_op_e          op;
    logic [WIDTH-1:0] as_sum;
    logic             as_co;
    logic [WIDTH-1:0] out_next;
    logic             co_next;

    assign op = alu_op_e'(S);

    // S[0] is the subtract select inside the arithmetic pair 010/011.
    alu_add_sub #(
        .WIDTH (WIDTH)
    ) u_add_sub (
        .a   (A),
        .b   (B),
        .ci  (CI),
        .sub (S[0]),
        .sum (as_sum),
        .co  (as_co)
    );

    always_comb begin
        out_next = '0;
        co_next  = 1'b0;
        case (op)
            OP_PASS_B: out_next = B;
            OP_ADD,
            OP_SUB:    out_next = as_sum;
            OP_AND:    out_next = A & B;
            OP_OR:     out_next = A | B;
            OP_XOR:    out_next = A ^ B;
            default:   out_next = '0;
        endcase
        if (alu_is_arith(op)) begin
            co_next = as_co;
        end
    end

    // Reset is tested first so unknown opcode bits never reach the
    // register while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            CO  <= 1'b0;
        end else begin
            out <= out_next;
            CO  <= co_next;
        end
    end

endmodule

// File: tb/tb_bit_alu_slice.sv
module tb_bit_alu_slice;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, b;
    logic       ci;
    logic [2:0] s;
    logic       out1, co1;
    logic [7:0] out8;
    logic       co8;

    logic [1:0] exp1_q[$];
    logic [8:0] exp8_q[$];
    logic       issued = 1'b0;
    logic       done = 1'b0;
    int         errors = 0;
    int         checks = 0;

    // Clock / reset
    always #5 clk = ~clk;

    bit_alu_slice #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .A(a[0]), .B(b[0]), .CI(ci), .S(s),
        .out(out1), .CO(co1)
    );

    bit_alu_slice #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .A(a), .B(b), .CI(ci), .S(s),
        .out(out8), .CO(co8)
    );

    // Reference model: {CO, out} from the opcode rules using plain integers.
    function automatic int model(input int w, input int rst, input int av,
                                 input int bv, input int civ, input int sv);
        int mask;
        int ax;
        int bx;
        mask = (1 << w) - 1;
        ax   = av & mask;
        bx   = bv & mask;
        if (rst != 0) return 0;
        case (sv)
            0:       return bx;
            2:       return ax + bx + civ;
            3:       return ax + (mask - bx) + civ;
            4:       return ax & bx;
            5:       return ax | bx;
            6:       return ax ^ bx;
            default: return 0;
        endcase
    endfunction

    // Driver: presents one operation per cycle and records the expectation.
    task automatic issue(input logic r, input logic [7:0] av, input logic [7:0] bv,
                         input logic c, input logic [2:0] sv);
        int e1;
        int e8;
        @(negedge clk);
        reset  = r;
        a      = av;
        b      = bv;
        ci     = c;
        s      = sv;
        e1 = model(1, int'(r), int'(av), int'(bv), int'(c), int'(sv));
        e8 = model(8, int'(r), int'(av), int'(bv), int'(c), int'(sv));
        exp1_q.push_back(e1[1:0]);
        exp8_q.push_back(e8[8:0]);
        issued = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset  = 1'b0;
            issued = 1'b0;
        end
    endtask

    // Monitor: an edge that captured an issued op yields one result each.
    initial begin : monitor
        logic       took;
        logic [1:0] e1;
        logic [8:0] e8;
        forever begin
            @(posedge clk);
            took = issued;
            #1;
            if (took) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    errors++;
                    $display("FAIL w1_underflow: result with empty expected queue");
                end else begin
                    e1 = exp1_q.pop_front();
                    if ({co1, out1} !== e1) begin
                        errors++;
                        $display("FAIL w1_result: got {CO,out}=%b want %b (t=%0t)",
                                 {co1, out1}, e1, $time);
                    end
                end
                checks++;
                if (exp8_q.size() == 0) begin
                    errors++;
                    $display("FAIL w8_underflow: result with empty expected queue");
                end else begin
                    e8 = exp8_q.pop_front();
                    if ({co8, out8} !== e8) begin
                        errors++;
                        $display("FAIL w8_result: got {CO,out}=%h want %h (t=%0t)",
                                 {co8, out8}, e8, $time);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        reset = 1'b1; a = '0; b = '0; ci = 1'b0; s = 3'b000;

        // Reset discards the concurrent add, then the add goes through.
        issue(1'b1, 8'd1, 8'd1, 1'b1, 3'b010);
        issue(1'b0, 8'd1, 8'd1, 1'b1, 3'b010);

        // Logic ops over all A,B pairs.
        for (int op = 4; op <= 6; op++)
            for (int ab = 0; ab < 4; ab++)
                issue(1'b0, 8'(ab >> 1), 8'(ab & 1), 1'b1, 3'(op));

        // Pass and reserved.
        issue(1'b0, 8'd1, 8'd0, 1'b1, 3'b000);
        issue(1'b0, 8'd0, 8'd1, 1'b1, 3'b000);
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 3'b001);
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 3'b111);

        // Add and subtract over all single-bit combinations.
        for (int op = 2; op <= 3; op++)
            for (int k = 0; k < 8; k++)
                issue(1'b0, 8'((k >> 2) & 1), 8'((k >> 1) & 1), k[0], 3'(op));

        // Wide boundary cases.
        issue(1'b0, 8'hFF, 8'h01, 1'b0, 3'b010);
        issue(1'b0, 8'h05, 8'h07, 1'b1, 3'b011);
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 3'b010);
        issue(1'b0, 8'h00, 8'h00, 1'b0, 3'b011);

        // Reset in the middle of a back-to-back stream.
        issue(1'b0, 8'h80, 8'h80, 1'b0, 3'b010);
        issue(1'b1, 8'hAA, 8'h55, 1'b0, 3'b101);
        issue(1'b0, 8'hAA, 8'h55, 1'b0, 3'b101);
        idle(2);

        // Randomized back-to-back traffic with occasional gaps and resets.
        for (int i = 0; i < 300; i++) begin
            issue(($urandom_range(0, 31) == 0), 8'($urandom), 8'($urandom),
                  1'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) == 0) idle(1);
        end

        idle(3);
        checks++;
        if (exp1_q.size() != 0 || exp8_q.size() != 0) begin
            errors++;
            $display("FAIL drain: leftover expected w1=%0d w8=%0d, want 0",
                     exp1_q.size(), exp8_q.size());
        end
        done = 1'b1;
    end

    // Final report, with a cycle budget so the run always ends.
    initial begin : report
        int cycles;
        cycles = 0;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            cycles++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL timeout: stimulus not finished after %0d cycles", cycles);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
